systolic_job_sched: RTL
=======================

Name: systolic_job_sched

Overview:
Top-level job sequencer for the systolic matrix-multiply array. It accepts a job-start handshake and enables the operand-load controller. It then releases the FIFO read wavefront and holds MAC enable through the array's skew flush. Finally it drains the size x size accumulator grid in raster order over a val/rdy port and clears the accumulators. Sits between the host/command interface and the array datapath (operand FIFOs, PE grid, output mux).

Parameters:
size, 4, array dimension (size x size PEs); must be >= 2
flush_cycles, 2*size-1, MAC cycles held after all operand FIFOs report empty, to let the last operands propagate through the skew

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_val  input  1  job request valid
start_rdy  output  1  job request ready
fifo_full  input  1  AND of all x and w operand FIFO full flags
fifo_empty  input  1  AND of all x and w operand FIFO empty flags
load_en  output  1  enables operand-load controller (accepts x/w streams)
ren_start  output  1  one-cycle pulse launching the FIFO read wavefront at column/row 0
mac_en  output  1  PE multiply-accumulate enable
out_val  output  1  result valid
out_rdy  input  1  result ready
out_row  output  $clog2(size)  row index of current result; drives output mux select
out_col  output  $clog2(size)  column index of current result
acc_clr  output  1  one-cycle pulse zeroing all PE accumulators
job_done  output  1  one-cycle pulse, job complete
busy  output  1  high in every state except IDLE

Behaviour:
- One clock (clk); reset synchronous, active-high (rst), sampled on posedge clk.
- rst: state=IDLE, flush counter=0, out_row=out_col=0, all outputs 0 except start_rdy=1. rst mid-job abandons the job immediately; no acc_clr or job_done is issued for it.
- States: IDLE, LOAD, MAC, FLUSH, DRAIN, CLEAR; one-hot encoding.
- IDLE: start_rdy=1. start_val&start_rdy -> LOAD next cycle. start_val is ignored in every other state (start_rdy=0).
- LOAD: load_en=1.
  - fifo_full=1 -> MAC next cycle, with ren_start=1 combinationally in that same LOAD cycle.
  - fifo_empty is ignored in LOAD.
- MAC: mac_en=1. fifo_empty=1 -> FLUSH next cycle; flush counter is loaded with 0.
- FLUSH: mac_en=1; counter increments every cycle.
  - At counter==flush_cycles-1 -> DRAIN next cycle. FLUSH therefore lasts exactly flush_cycles cycles.
  - Counter width $clog2(flush_cycles+1).
- DRAIN: mac_en=0, out_val=1; out_row/out_col are registered.
  - Index update happens only on out_val&out_rdy.
  - out_col==size-1: out_col wraps to 0 and out_row increments; otherwise out_col increments.
  - Handshake at (size-1,size-1) -> CLEAR; indices return to 0.
  - out_rdy=0 holds out_val, out_row and out_col stable; no timeout.
- CLEAR: exactly one cycle with acc_clr=1, job_done=1, then -> IDLE. A new start is accepted no earlier than the cycle after CLEAR.
- Per-job latency, for out_rdy held high:
  - load cycles, plus MAC cycles until empty, plus flush_cycles, plus size*size drain cycles, plus 1 CLEAR cycle.
- Outputs are combinational decodes of registered state/counters. ren_start is the only output that also depends on an input (fifo_full); no other input-to-output paths.
- Illegal state encoding -> IDLE next cycle.

Test Plan:
- Basic job, size=4, out_rdy=1: start pulse; fifo_full after 4 cycles; fifo_empty 6 cycles later. Required response:
  - ren_start pulses once.
  - mac_en high for 6+7 cycles.
  - 16 consecutive out_val beats indexed (0,0),(0,1)..(3,3).
  - acc_clr and job_done high for exactly 1 cycle, then start_rdy=1.
- Backpressure: toggle out_rdy 1,0,0,1,... during DRAIN -> indices advance only on handshake; exactly 16 accepted beats; out_row/out_col stable while out_rdy=0.
- Start while busy: assert start_val continuously through a job -> start_rdy=0 until IDLE. A second job begins the cycle after job_done and is accepted exactly once.
- Reset mid-DRAIN at beat (2,1) -> next cycle state IDLE, out_val=0, indices 0, no acc_clr/job_done. A subsequent job drains from (0,0).
- size=2 (flush_cycles=3): full job -> FLUSH lasts 3 cycles, 4 drain beats (0,0),(0,1),(1,0),(1,1).
- fifo_full and fifo_empty both 1 in LOAD -> goes to MAC (not FLUSH). In the next cycle, with fifo_empty still 1, MAC -> FLUSH; mac_en is high for at least 1+flush_cycles cycles.

Source files
------------

// File: rtl/systolic_job_sched.sv
// Job sequencer for the systolic matrix-multiply array: accepts a job, runs
// operand load, MAC and skew flush, drains the accumulator grid in raster
// order, then clears the accumulators and reports completion.
module systolic_job_sched #(
    parameter int size         = 4,
    parameter int flush_cycles = 2*size-1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_val,
    output logic                    start_rdy,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic                    load_en,
    output logic                    ren_start,
    output logic                    mac_en,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [$clog2(size)-1:0] out_row,
    output logic [$clog2(size)-1:0] out_col,
    output logic                    acc_clr,
    output logic                    job_done,
    output logic                    busy
);
    localparam int IW = $clog2(size);
    localparam int CW = $clog2(flush_cycles+1);
    localparam logic [IW-1:0] IDX_LAST = IW'(size-1);
    localparam logic [CW-1:0] CNT_LAST = CW'(flush_cycles-1);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        LOAD  = 6'b000010,
        MAC   = 6'b000100,
        FLUSH = 6'b001000,
        DRAIN = 6'b010000,
        CLEAR = 6'b100000
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] flush_cnt;
    logic          last_beat;

    assign last_beat = (out_row == IDX_LAST) && (out_col == IDX_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state and output decode; anything not one-hot falls back to IDLE
    always_comb begin
        state_nx  = state;
        start_rdy = 1'b0;
        load_en   = 1'b0;
        ren_start = 1'b0;
        mac_en    = 1'b0;
        out_val   = 1'b0;
        acc_clr   = 1'b0;
        job_done  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                start_rdy = 1'b1;
                busy      = 1'b0;
                if (start_val) state_nx = LOAD;
            end
            LOAD: begin
                load_en = 1'b1;
                if (fifo_full) begin
                    ren_start = 1'b1;
                    state_nx  = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (fifo_empty) state_nx = FLUSH;
            end
            FLUSH: begin
                mac_en = 1'b1;
                if (flush_cnt == CNT_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                out_val = 1'b1;
                if (out_rdy && last_beat) state_nx = CLEAR;
            end
            CLEAR: begin
                acc_clr  = 1'b1;
                job_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // flush counter: zeroed on the MAC->FLUSH transition, counts through FLUSH
    always_ff @(posedge clk) begin
        if (rst)                          flush_cnt <= '0;
        else if (state == MAC && fifo_empty) flush_cnt <= '0;
        else if (state == FLUSH)          flush_cnt <= flush_cnt + CW'(1);
    end

    // raster drain indices; advance only on an accepted beat, wrap to (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_row <= '0;
            out_col <= '0;
        end else if (state == DRAIN && out_rdy) begin
            if (out_col == IDX_LAST) begin
                out_col <= '0;
                out_row <= (out_row == IDX_LAST) ? '0 : out_row + IW'(1);
            end else begin
                out_col <= out_col + IW'(1);
            end
        end
    end

endmodule
